sigmoid_share_sched: RTL and testbench

- Round-robin scheduler that shares one pipelined sigmoid activation unit among NREQ neuron requesters.
- Accepts one sample per cycle from the granted requester and drives it into the sigmoid unit's data input.
- Tracks each in-flight sample's requester ID through a tag pipeline matched to the sigmoid latency.
- Returns each result on a broadcast result bus tagged with that ID. It sits between the neuron-layer accumulators and the shared activation datapath.

---
 rtl/activation_pkg.sv | 16 +
 rtl/sigmoid_share_sched_rr_arbiter.sv | 59 +++++
 rtl/sigmoid_share_sched.sv | 121 ++++++++++++
 tb/tb_sigmoid_share_sched.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/activation_pkg.sv
// Shared constants for the activation datapath and its schedulers.
// Latency: n/a (constants only).
// Backpressure: n/a.
//
// Fixed-point format used throughout the activation path: signed 16-bit
// with 11 fraction bits (Q4.11). ONE_HALF is sigmoid(0) in that format.
package activation_pkg;

   localparam int                    BITSIZE   = 16;
   localparam int                    FRAC_BITS = 11;
   localparam logic [BITSIZE-1:0]    ONE_HALF  = 16'h0400;

   // Default pipeline depth of the shared sigmoid unit, data in to data out.
   localparam int                    SIG_LAT   = 2;

endpackage

// File: rtl/sigmoid_share_sched_rr_arbiter.sv
// Round-robin arbiter: picks one requester starting after the last winner.
// Latency: combinational grant; pointer updates on the accepting edge.
// Backpressure: no grant while en is low or reset is high; a requester that
// drops its request without being accepted leaves the pointer untouched.
//
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   en          - grant enable
//   advance     - a handshake happens at the coming edge; move the pointer
//   req[N]      - request vector
//   grant[N]    - one-hot grant (all zero when nothing wins)
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic         advance,
   input  logic [N-1:0] req,
   output logic [N-1:0] grant
);

   localparam int PW = $clog2(N);

   logic [PW-1:0] r_last;
   logic [N-1:0]  w_grant;
   logic [PW-1:0] w_win;
   logic [PW-1:0] w_idx;
   logic          w_found;

   // Walk the ring starting one past the previous winner; the first active
   // request seen wins. The modulo keeps non-power-of-two N on the ring.
   always_comb begin
      w_grant = '0;
      w_win   = '0;
      w_idx   = '0;
      w_found = 1'b0;
      for (int k = 0; k < N; k++) begin
         w_idx = PW'((int'(r_last) + 1 + k) % N);
         if (!w_found && req[w_idx]) begin
            w_grant[w_idx] = 1'b1;
            w_win          = w_idx;
            w_found        = 1'b1;
         end
      end
   end

   assign grant = (en && !reset) ? w_grant : '0;

   // Resetting to N-1 makes requester 0 the first in line.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_last <= PW'(N - 1);
      end else if (advance && en) begin
         r_last <= w_win;
      end
   end

endmodule

// File: rtl/sigmoid_share_sched.sv
// Shares one pipelined sigmoid unit among NREQ requesters, round-robin.
// Latency: accept at edge k -> result on the broadcast bus after edge k+LAT.
// Backpressure: one grant per cycle via req_ready; no result backpressure.
//
// Ports:
//   clk, reset   - clock, asynchronous active-high reset (shared with the
//                  sigmoid unit)
//   en           - grant enable; in-flight samples drain regardless
//   req_valid    - per-requester sample valid
//   req_data     - per-requester sample, requester i at [i*BITSIZE +: BITSIZE]
//   req_ready    - one-hot accept
//   sig_in       - issue register, feeds the sigmoid unit data input
//   sig_out      - sigmoid unit data output
//   res_valid    - one-cycle result strobe per accepted sample
//   res_id       - requester that owns the result
//   res_data     - result value, zero whenever res_valid is low
//   busy         - any sample between issue and result
module sigmoid_share_sched
   import activation_pkg::*;
#(
   parameter int BITSIZE = activation_pkg::BITSIZE,
   parameter int NREQ    = 4,
   parameter int LAT     = SIG_LAT,
   parameter int IDW     = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    en,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ*BITSIZE-1:0] req_data,
   output logic [NREQ-1:0]         req_ready,
   output logic [BITSIZE-1:0]      sig_in,
   input  logic [BITSIZE-1:0]      sig_out,
   output logic                    res_valid,
   output logic [IDW-1:0]          res_id,
   output logic [BITSIZE-1:0]      res_data,
   output logic                    busy
);

   logic [NREQ-1:0]         w_grant;
   logic                    w_hs;
   logic [IDW-1:0]          w_sel;
   logic [BITSIZE-1:0]      w_data;

   logic                    r_iss_v;
   logic [IDW-1:0]          r_iss_id;
   logic [BITSIZE-1:0]      r_iss_dat;

   // Tag stage s holds the ID of the sample that is s+1 edges into the
   // sigmoid unit; the last stage lines up with sig_out.
   logic [LAT-1:0]          r_tag_v;
   logic [LAT-1:0][IDW-1:0] r_tag_id;

   rr_arbiter #(
      .N       (NREQ)
   ) u_arb (
      .clk     (clk),
      .reset   (reset),
      .en      (en),
      .advance (w_hs),
      .req     (req_valid),
      .grant   (w_grant)
   );

   assign req_ready = w_grant;

   // The grant only ever covers a valid request, but qualifying with
   // req_valid keeps the handshake definition self-evident.
   assign w_hs = |(req_valid & w_grant);

   always_comb begin
      w_sel = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_grant[i]) begin
            w_sel = IDW'(i);
         end
      end
   end

   assign w_data = req_data[int'(w_sel)*BITSIZE +: BITSIZE];

   // Issue register: the data holds on idle edges so sig_in stays quiet;
   // only the valid bit drops.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_iss_v   <= 1'b0;
         r_iss_id  <= '0;
         r_iss_dat <= '0;
      end else begin
         r_iss_v <= w_hs;
         if (w_hs) begin
            r_iss_id  <= w_sel;
            r_iss_dat <= w_data;
         end
      end
   end

   assign sig_in = r_iss_dat;

   // Free-running shift; the sigmoid unit never stalls, so neither does
   // the tag that shadows it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_tag_v  <= '0;
         r_tag_id <= '0;
      end else begin
         r_tag_v[0]  <= r_iss_v;
         r_tag_id[0] <= r_iss_id;
         for (int s = 1; s < LAT; s++) begin
            r_tag_v[s]  <= r_tag_v[s-1];
            r_tag_id[s] <= r_tag_id[s-1];
         end
      end
   end

   assign res_valid = r_tag_v[LAT-1];
   assign res_id    = r_tag_id[LAT-1];
   assign res_data  = res_valid ? sig_out : '0;
   assign busy      = r_iss_v | (|r_tag_v);

endmodule

// File: tb/tb_sigmoid_share_sched.sv
module tb_sigmoid_share_sched;

   localparam int BITSIZE = 16;
   localparam int NREQ    = 4;
   localparam int LAT     = 2;
   localparam int IDW     = 2;

   logic                    clk = 1'b0;
   logic                    reset;
   logic                    en;
   logic [NREQ-1:0]         req_valid;
   logic [NREQ*BITSIZE-1:0] req_data;
   logic [NREQ-1:0]         req_ready;
   logic [BITSIZE-1:0]      sig_in;
   logic [BITSIZE-1:0]      sig_out;
   logic                    res_valid;
   logic [IDW-1:0]          res_id;
   logic [BITSIZE-1:0]      res_data;
   logic                    busy;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      int          id;
      logic [15:0] dat;
      int          due;
   } exp_t;

   exp_t        q[$];
   int          m_last = NREQ - 1;
   logic [15:0] m_iss  = '0;

   sigmoid_share_sched #(
      .BITSIZE   (BITSIZE),
      .NREQ      (NREQ),
      .LAT       (LAT),
      .IDW       (IDW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .sig_in    (sig_in),
      .sig_out   (sig_out),
      .res_valid (res_valid),
      .res_id    (res_id),
      .res_data  (res_data),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Q4.11 logistic function, rounded to nearest.
   function automatic logic [15:0] sig_ref(input logic [15:0] x);
      real xr;
      real y;
      int  v;
      xr = $itor($signed(x)) / 2048.0;
      y  = 1.0 / (1.0 + $exp(-xr));
      v  = $rtoi(y * 2048.0 + 0.5);
      if (v > 32767) v = 32767;
      return v[15:0];
   endfunction

   // Behavioural sigmoid unit: LAT=2 register stages on clk/reset.
   logic [15:0] s0;
   logic [15:0] s1;
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         s0 <= '0;
         s1 <= '0;
      end else begin
         s0 <= sig_ref(sig_in);
         s1 <= s0;
      end
   end
   assign sig_out = s1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, req, cyc);
      end
   endtask

   // One cycle of stimulus: check the issue register, drive inputs, check
   // the grant against the round-robin rule, record the expected result.
   task automatic step(input logic e, input logic [NREQ-1:0] v,
                       input logic [NREQ*BITSIZE-1:0] d, input logic rst);
      int              win;
      logic [NREQ-1:0] exp_rdy;
      @(negedge clk);
      #1;
      chk("sig_in", 32'(sig_in), 32'(m_iss));
      reset     = rst;
      en        = e;
      req_valid = v;
      req_data  = d;
      if (rst) begin
         q.delete();
         m_last = NREQ - 1;
         m_iss  = '0;
      end
      #1;
      win = -1;
      if (e && !rst) begin
         for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (m_last + 1 + k) % NREQ;
            if (win < 0 && v[j]) win = j;
         end
      end
      exp_rdy = '0;
      if (win >= 0) exp_rdy[win] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      if (win >= 0) begin
         exp_t x;
         x.id  = win;
         x.dat = sig_ref(d[win*BITSIZE +: BITSIZE]);
         x.due = cyc + 1 + LAT;
         q.push_back(x);
         m_last = win;
         m_iss  = d[win*BITSIZE +: BITSIZE];
      end
   endtask

   // Monitor: every cycle, either the oldest outstanding sample is due and
   // must appear, or the bus must be idle with zero data.
   initial begin
      forever begin
         @(negedge clk);
         chk("busy", 32'(busy), 32'(q.size() > 0));
         if (reset) chk("res_id_in_reset", 32'(res_id), 32'd0);
         if (q.size() > 0 && q[0].due == cyc) begin
            chk("res_valid", 32'(res_valid), 32'd1);
            chk("res_id", 32'(res_id), 32'(q[0].id));
            chk("res_data", 32'(res_data), 32'(q[0].dat));
            void'(q.pop_front());
         end else begin
            chk("res_valid_idle", 32'(res_valid), 32'd0);
            chk("res_data_idle", 32'(res_data), 32'd0);
         end
      end
   end

   initial begin
      logic [NREQ*BITSIZE-1:0] d;
      logic [NREQ-1:0]         v;
      logic                    e;
      logic                    r;
      reset     = 1'b1;
      en        = 1'b0;
      req_valid = '0;
      req_data  = '0;

      repeat (3) step(1'b0, 4'b0000, 64'd0, 1'b1);

      // Single request from requester 2 with zero data: sigmoid(0)=0x0400.
      step(1'b1, 4'b0100, 64'd0, 1'b0);
      repeat (4) step(1'b1, 4'b0000, 64'd0, 1'b0);

      // All requesters valid, data of requester i = i: strict rotation.
      d = {16'd3, 16'd2, 16'd1, 16'd0};
      repeat (8) step(1'b1, 4'b1111, d, 1'b0);
      repeat (3) step(1'b1, 4'b0000, 64'd0, 1'b0);

      // Single active requester granted every cycle.
      repeat (5) begin
         d = {$urandom, $urandom};
         step(1'b1, 4'b0010, d, 1'b0);
      end
      repeat (3) step(1'b1, 4'b0000, 64'd0, 1'b0);

      // en drops after two accepts while requests stay valid.
      repeat (2) begin
         d = {$urandom, $urandom};
         step(1'b1, 4'b1111, d, 1'b0);
      end
      repeat (5) begin
         d = {$urandom, $urandom};
         step(1'b0, 4'b1111, d, 1'b0);
      end

      // Reset one cycle after an accept: that sample must never appear.
      d = {$urandom, $urandom};
      step(1'b1, 4'b1000, d, 1'b0);
      step(1'b0, 4'b0000, 64'd0, 1'b1);
      repeat (4) step(1'b0, 4'b0000, 64'd0, 1'b0);
      d = {$urandom, $urandom};
      step(1'b1, 4'b0001, d, 1'b0);

      // Quiet period.
      repeat (10) begin
         d = {$urandom, $urandom};
         step(1'b1, 4'b0000, d, 1'b0);
      end

      // Random traffic with occasional en drops and reset pulses.
      repeat (500) begin
         v = 4'($urandom);
         d = {$urandom, $urandom};
         e = ($urandom_range(0, 9) != 0);
         r = ($urandom_range(0, 59) == 0);
         step(e, v, d, r);
      end

      repeat (LAT + 3) step(1'b1, 4'b0000, 64'd0, 1'b0);
      chk("drained", 32'(q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
